// File: rtl/trojan_response_checker_if.sv
// Sample channel into the trojan response checker: one (input vector, observed response) pair per transfer.
interface trojan_response_checker_if #(
    parameter int N_IN = 3
);
    // A transfer happens on a rising clock edge where in_valid and in_ready are both high.
    // in_ready depends only on checker state. The sender holds in_vec/in_resp stable while
    // in_valid is high and not yet accepted.
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            in_resp;

    modport master (output in_valid, output in_vec, output in_resp, input in_ready);
    modport slave  (input in_valid, input in_vec, input in_resp, output in_ready);
endinterface

// File: rtl/trojan_response_checker.sv
// Rebuilds a DUT's observed truth table from sampled (vector, response) pairs and compares it with GOLDEN;
// raises trojan_flag once every vector has been covered and at least one first-time sample disagreed.
module trojan_response_checker #(
    parameter int                   N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0] GOLDEN = 8'b1001_0110,
    parameter int                   CNT_W  = 8
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    trojan_response_checker_if.slave   smp,
    output logic [(1<<N_IN)-1:0]       covered,
    output logic [(1<<N_IN)-1:0]       observed_tt,
    output logic [CNT_W-1:0]           mismatch_cnt,
    output logic                       dup_err,
    output logic                       done,
    output logic                       trojan_flag,
    output logic [1:0]                 state_dbg
);
    localparam int              DEPTH   = 1 << N_IN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;

    state_t            state, next_state;
    logic              accept;
    logic [DEPTH-1:0]  covered_n, observed_n;
    logic [CNT_W-1:0]  mismatch_n;
    logic              dup_n;

    assign smp.in_ready = (state == COLLECT);
    assign accept       = smp.in_valid && smp.in_ready;
    assign state_dbg    = state;

    // Sample bookkeeping: only the first sample of a vector is recorded and scored.
    always_comb begin
        covered_n  = covered;
        observed_n = observed_tt;
        mismatch_n = mismatch_cnt;
        dup_n      = dup_err;
        if (accept) begin
            if (covered[smp.in_vec]) begin
                dup_n = 1'b1;
            end else begin
                covered_n[smp.in_vec]  = 1'b1;
                observed_n[smp.in_vec] = smp.in_resp;
                if ((smp.in_resp != GOLDEN[smp.in_vec]) && (mismatch_cnt != CNT_MAX))
                    mismatch_n = mismatch_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COLLECT;
            COLLECT: if (start) next_state = COLLECT;
                     else if (&covered_n) next_state = DONE;
            DONE:    if (start) next_state = COLLECT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        state <= next_state;
        if (reset) state <= IDLE;
    end

    // start clears the collection and drops any sample offered on the same edge.
    always_ff @(posedge CK) begin
        if (reset) begin
            covered      <= '0;
            observed_tt  <= '0;
            mismatch_cnt <= '0;
            dup_err      <= 1'b0;
            done         <= 1'b0;
            trojan_flag  <= 1'b0;
        end else if (start) begin
            covered      <= '0;
            observed_tt  <= '0;
            mismatch_cnt <= '0;
            dup_err      <= 1'b0;
            done         <= 1'b0;
            trojan_flag  <= 1'b0;
        end else begin
            covered      <= covered_n;
            observed_tt  <= observed_n;
            mismatch_cnt <= mismatch_n;
            dup_err      <= dup_n;
            done         <= (next_state == DONE);
            trojan_flag  <= (next_state == DONE) && (mismatch_n != '0);
        end
    end
endmodule
